// File: rtl/hft_gw_pkg.sv
// Shared constants and the order record for the HFT order gateway.
// Signal codes, reject codes and sides match the upstream signal core and TX stage.
package hft_gw_pkg;

    localparam int GW_PRICE_W = 32;
    localparam int GW_QTY_W   = 16;

    localparam logic [1:0] SIG_NONE = 2'b00;
    localparam logic [1:0] SIG_BUY  = 2'b01;
    localparam logic [1:0] SIG_SELL = 2'b10;
    localparam logic [1:0] SIG_FLAT = 2'b11;

    localparam logic [1:0] REJ_HALTED   = 2'b00;
    localparam logic [1:0] REJ_POSITION = 2'b01;
    localparam logic [1:0] REJ_THROTTLE = 2'b10;
    localparam logic [1:0] REJ_FULL     = 2'b11;

    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

    typedef struct packed {
        logic                  side;
        logic [GW_QTY_W-1:0]   qty;
        logic [GW_PRICE_W-1:0] price;
    } order_t;

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_HALT = 1'b1
    } gw_mode_e;

endpackage

// File: rtl/hft_gw_fifo.sv
// Show-ahead order FIFO with a registered head entry and registered full/valid flags.
// A push is taken only when not full; push and pop may coincide.
module hft_gw_fifo
    import hft_gw_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  order_t din,
    input  logic   pop,
    output order_t head,
    output logic   valid,
    output logic   full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    order_t          mem_r [DEPTH];
    order_t          head_r;
    order_t          head_next_s;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic [AW:0]     count_next_s;
    logic            valid_r;
    logic            full_r;
    logic            do_push_s;
    logic            do_pop_s;

    assign do_push_s = push && !full_r;
    assign do_pop_s  = pop && valid_r;

    // Next occupancy and next head entry (bypass the pushed word when it becomes head)
    always_comb begin
        count_next_s = count_r;
        head_next_s  = head_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_next_s = count_r + (AW+1)'(1);
            2'b01:   count_next_s = count_r - (AW+1)'(1);
            default: count_next_s = count_r;
        endcase
        if (do_pop_s && (count_r > (AW+1)'(1))) begin
            head_next_s = mem_r[rd_ptr_r + AW'(1)];
        end else if (do_push_s && ((count_r == (AW+1)'(0)) || do_pop_s)) begin
            head_next_s = din;
        end else begin
            head_next_s = head_r;
        end
    end

    // Storage array write
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and registered head/flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            head_r   <= '0;
            valid_r  <= 1'b0;
            full_r   <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            head_r  <= head_next_s;
            valid_r <= (count_next_s != (AW+1)'(0));
            full_r  <= (count_next_s == (AW+1)'(DEPTH));
        end
    end

    assign head  = head_r;
    assign valid = valid_r;
    assign full  = full_r;

endmodule

// File: rtl/hft_order_gateway.sv
// Pre-trade risk gateway: sizes trade signals into orders, applies halt, position-limit,
// token-bucket and queue-full checks, and streams accepted orders with sequence numbers.
module hft_order_gateway
    import hft_gw_pkg::*;
#(
    parameter int PRICE_W       = GW_PRICE_W,
    parameter int QTY_W         = GW_QTY_W,
    parameter int POS_W         = 18,
    parameter int ORDER_QTY     = 100,
    parameter int MAX_POS       = 300,
    parameter int TOKENS_MAX    = 4,
    parameter int REFILL_CYCLES = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int SEQ_W         = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sig_valid,
    input  logic [1:0]              sig_code,
    input  logic [PRICE_W-1:0]      sig_price,
    input  logic                    kill,
    input  logic                    resume,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_side,
    output logic [QTY_W-1:0]        out_qty,
    output logic [PRICE_W-1:0]      out_price,
    output logic [SEQ_W-1:0]        out_seq,
    output logic                    rej_valid,
    output logic [1:0]              rej_code,
    output logic signed [POS_W-1:0] position,
    output logic                    halted
);
    localparam int TOK_W = $clog2(TOKENS_MAX + 1);
    localparam int REF_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
    localparam logic signed [POS_W:0] POS_LIMIT = (POS_W+1)'(MAX_POS);

    gw_mode_e                mode_r, mode_next_s;
    logic                    halted_r;
    logic [TOK_W-1:0]        tokens_r, tokens_next_s;
    logic [REF_W-1:0]        refill_cnt_r;
    logic signed [POS_W-1:0] position_r, position_next_s;
    logic [SEQ_W-1:0]        seq_r;
    logic                    rej_valid_r;
    logic [1:0]              rej_code_r, rej_code_s;

    logic                    cand_s, is_flat_s, drop_s, accept_s, reject_s;
    logic                    consume_s, refill_s, over_limit_s;
    logic                    side_s;
    logic [QTY_W-1:0]        qty_s;
    logic signed [POS_W:0]   pos_ext_s, neg_pos_s, dpos_s, pos_sum_s, pos_abs_s;

    order_t                  push_rec_s, head_s;
    logic                    fifo_valid_s, fifo_full_s, pop_s;

    assign cand_s    = sig_valid && (sig_code != SIG_NONE);
    assign is_flat_s = (sig_code == SIG_FLAT);
    assign pos_ext_s = {position_r[POS_W-1], position_r};
    assign neg_pos_s = -pos_ext_s;
    assign pos_sum_s = pos_ext_s + dpos_s;
    assign pos_abs_s = pos_sum_s[POS_W] ? -pos_sum_s : pos_sum_s;
    assign over_limit_s = (pos_abs_s > POS_LIMIT);

    // Order sizing from the signal code and current position
    always_comb begin
        side_s = SIDE_BUY;
        qty_s  = {QTY_W{1'b0}};
        dpos_s = {(POS_W+1){1'b0}};
        drop_s = 1'b0;
        case (sig_code)
            SIG_BUY: begin
                side_s = SIDE_BUY;
                qty_s  = QTY_W'(ORDER_QTY);
                dpos_s = (POS_W+1)'(ORDER_QTY);
            end
            SIG_SELL: begin
                side_s = SIDE_SELL;
                qty_s  = QTY_W'(ORDER_QTY);
                dpos_s = -((POS_W+1)'(ORDER_QTY));
            end
            SIG_FLAT: begin
                if (position_r == {POS_W{1'b0}}) begin
                    drop_s = 1'b1;
                end else if (position_r[POS_W-1]) begin
                    side_s = SIDE_BUY;
                    qty_s  = neg_pos_s[QTY_W-1:0];
                    dpos_s = neg_pos_s;
                end else begin
                    side_s = SIDE_SELL;
                    qty_s  = position_r[QTY_W-1:0];
                    dpos_s = neg_pos_s;
                end
            end
            default: drop_s = 1'b1;
        endcase
    end

    // Risk checks, first failure wins; FLATTEN skips halt, limit and throttle
    always_comb begin
        accept_s   = 1'b0;
        reject_s   = 1'b0;
        rej_code_s = REJ_HALTED;
        if (!cand_s || drop_s) begin
            accept_s = 1'b0;
        end else if ((mode_r == MODE_HALT) && !is_flat_s) begin
            reject_s   = 1'b1;
            rej_code_s = REJ_HALTED;
        end else if (!is_flat_s && over_limit_s) begin
            reject_s   = 1'b1;
            rej_code_s = REJ_POSITION;
        end else if (!is_flat_s && (tokens_r == {TOK_W{1'b0}})) begin
            reject_s   = 1'b1;
            rej_code_s = REJ_THROTTLE;
        end else if (fifo_full_s) begin
            reject_s   = 1'b1;
            rej_code_s = REJ_FULL;
        end else begin
            accept_s = 1'b1;
        end
    end

    assign consume_s = accept_s && !is_flat_s;
    assign refill_s  = (refill_cnt_r == REF_W'(REFILL_CYCLES - 1));

    // Token bucket and position next-state
    always_comb begin
        if (consume_s && refill_s) begin
            tokens_next_s = tokens_r;
        end else if (consume_s) begin
            tokens_next_s = tokens_r - TOK_W'(1);
        end else if (refill_s && (tokens_r < TOK_W'(TOKENS_MAX))) begin
            tokens_next_s = tokens_r + TOK_W'(1);
        end else begin
            tokens_next_s = tokens_r;
        end
        if (accept_s && is_flat_s) begin
            position_next_s = {POS_W{1'b0}};
        end else if (accept_s) begin
            position_next_s = pos_sum_s[POS_W-1:0];
        end else begin
            position_next_s = position_r;
        end
    end

    // Mode FSM next state; kill dominates resume
    always_comb begin
        mode_next_s = mode_r;
        case (mode_r)
            MODE_RUN: begin
                if (kill) mode_next_s = MODE_HALT;
                else      mode_next_s = MODE_RUN;
            end
            MODE_HALT: begin
                if (kill)        mode_next_s = MODE_HALT;
                else if (resume) mode_next_s = MODE_RUN;
                else             mode_next_s = MODE_HALT;
            end
            default: mode_next_s = MODE_RUN;
        endcase
    end

    // Gateway state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_r       <= MODE_RUN;
            halted_r     <= 1'b0;
            tokens_r     <= TOK_W'(TOKENS_MAX);
            refill_cnt_r <= {REF_W{1'b0}};
            position_r   <= {POS_W{1'b0}};
            seq_r        <= {SEQ_W{1'b0}};
            rej_valid_r  <= 1'b0;
            rej_code_r   <= REJ_HALTED;
        end else begin
            mode_r       <= mode_next_s;
            halted_r     <= (mode_next_s == MODE_HALT);
            tokens_r     <= tokens_next_s;
            refill_cnt_r <= refill_s ? {REF_W{1'b0}} : refill_cnt_r + REF_W'(1);
            position_r   <= position_next_s;
            seq_r        <= pop_s ? seq_r + SEQ_W'(1) : seq_r;
            rej_valid_r  <= reject_s;
            rej_code_r   <= reject_s ? rej_code_s : REJ_HALTED;
        end
    end

    // Record pushed into the queue
    always_comb begin
        push_rec_s       = '0;
        push_rec_s.side  = side_s;
        push_rec_s.qty   = qty_s;
        push_rec_s.price = sig_price;
    end

    assign pop_s = fifo_valid_s && out_ready;

    hft_gw_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept_s),
        .din   (push_rec_s),
        .pop   (pop_s),
        .head  (head_s),
        .valid (fifo_valid_s),
        .full  (fifo_full_s)
    );

    assign out_valid = fifo_valid_s;
    assign out_side  = head_s.side;
    assign out_qty   = head_s.qty;
    assign out_price = head_s.price;
    assign out_seq   = seq_r;
    assign rej_valid = rej_valid_r;
    assign rej_code  = rej_code_r;
    assign position  = position_r;
    assign halted    = halted_r;

endmodule

// File: tb/tb_hft_order_gateway.sv
// Bench for hft_order_gateway: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_hft_order_gateway;
    import hft_gw_pkg::*;

    localparam int PRICE_W = 32, QTY_W = 16, POS_W = 18, ORDER_QTY = 100, MAX_POS = 300;
    localparam int TOKENS_MAX = 4, REFILL_CYCLES = 16, FIFO_DEPTH = 4, SEQ_W = 16;

    logic clk = 1'b0;
    logic reset;
    logic sig_valid = 1'b0, kill = 1'b0, resume = 1'b0, out_ready = 1'b0;
    logic [1:0] sig_code = 2'b00;
    logic [PRICE_W-1:0] sig_price = 32'd0;
    logic out_valid, out_side, rej_valid, halted;
    logic [QTY_W-1:0] out_qty;
    logic [PRICE_W-1:0] out_price;
    logic [SEQ_W-1:0] out_seq;
    logic [1:0] rej_code;
    logic signed [POS_W-1:0] position;

    int total = 0;
    int bad = 0;

    hft_order_gateway #(
        .PRICE_W(PRICE_W), .QTY_W(QTY_W), .POS_W(POS_W), .ORDER_QTY(ORDER_QTY),
        .MAX_POS(MAX_POS), .TOKENS_MAX(TOKENS_MAX), .REFILL_CYCLES(REFILL_CYCLES),
        .FIFO_DEPTH(FIFO_DEPTH), .SEQ_W(SEQ_W)
    ) dut (
        .clk(clk), .reset(reset), .sig_valid(sig_valid), .sig_code(sig_code),
        .sig_price(sig_price), .kill(kill), .resume(resume), .out_valid(out_valid),
        .out_ready(out_ready), .out_side(out_side), .out_qty(out_qty),
        .out_price(out_price), .out_seq(out_seq), .rej_valid(rej_valid),
        .rej_code(rej_code), .position(position), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: queue of pending orders and plain integer risk state
    typedef struct {
        int     side;
        int     qty;
        longint price;
    } mord_t;
    mord_t m_q[$];
    mord_t m_o;
    int m_pos, m_tok, m_ref, m_seq, m_np, m_rc;
    bit m_halt, m_rv, m_xfer, m_full, m_acc, m_flat, m_refill;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_pos = 0; m_tok = TOKENS_MAX; m_ref = 0; m_seq = 0;
            m_halt = 1'b0; m_rv = 1'b0; m_rc = 0;
        end else begin
            m_xfer = (m_q.size() != 0) && out_ready;
            m_full = (m_q.size() == FIFO_DEPTH);
            m_flat = (sig_code == 2'b11);
            m_acc  = 1'b0;
            m_rv   = 1'b0;
            m_o.side = 0; m_o.qty = 0; m_o.price = sig_price; m_np = m_pos;
            if (sig_code == 2'b01) begin
                m_o.qty = ORDER_QTY; m_np = m_pos + ORDER_QTY;
            end else if (sig_code == 2'b10) begin
                m_o.side = 1; m_o.qty = ORDER_QTY; m_np = m_pos - ORDER_QTY;
            end else begin
                m_o.side = (m_pos > 0) ? 1 : 0;
                m_o.qty  = (m_pos > 0) ? m_pos : -m_pos;
                m_np = 0;
            end
            if (!sig_valid || sig_code == 2'b00 || (m_flat && m_pos == 0)) m_acc = 1'b0;
            else if (m_halt && !m_flat) begin m_rv = 1'b1; m_rc = 0; end
            else if (!m_flat && (m_np > MAX_POS || m_np < -MAX_POS)) begin m_rv = 1'b1; m_rc = 1; end
            else if (!m_flat && m_tok == 0) begin m_rv = 1'b1; m_rc = 2; end
            else if (m_full) begin m_rv = 1'b1; m_rc = 3; end
            else m_acc = 1'b1;
            m_refill = (m_ref == REFILL_CYCLES - 1);
            m_ref = (m_ref + 1) % REFILL_CYCLES;
            m_tok = m_tok + (m_refill ? 1 : 0) - ((m_acc && !m_flat) ? 1 : 0);
            if (m_tok > TOKENS_MAX) m_tok = TOKENS_MAX;
            if (m_xfer) begin
                void'(m_q.pop_front());
                m_seq = (m_seq + 1) % (1 << SEQ_W);
            end
            if (m_acc) begin
                m_q.push_back(m_o);
                m_pos = m_np;
            end
            if (kill) m_halt = 1'b1;
            else if (resume) m_halt = 1'b0;
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (!reset) begin
            check("cmp_out_valid", out_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                check("cmp_side", out_side, m_q[0].side);
                check("cmp_qty", out_qty, m_q[0].qty);
                check("cmp_price", out_price, m_q[0].price);
                check("cmp_seq", out_seq, m_seq);
            end
            check("cmp_rej_valid", rej_valid, m_rv);
            if (m_rv) check("cmp_rej_code", rej_code, m_rc);
            check("cmp_position", $signed(position), m_pos);
            check("cmp_halted", halted, m_halt);
        end
    end

    task automatic send(input logic [1:0] c, input int p);
        sig_valid = 1'b1; sig_code = c; sig_price = p;
        @(negedge clk);
        sig_valid = 1'b0; sig_code = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_seq", out_seq, 0);
        check("rst_out_qty", out_qty, 0);
        check("rst_position", $signed(position), 0);
        check("rst_halted", halted, 0);
        check("rst_rej_valid", rej_valid, 0);
        reset = 1'b0;

        // Three spaced BUYs reach the position limit; a fourth is rejected
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(SIG_BUY, 1000);
            check("t1_valid", out_valid, 1);
            check("t1_side", out_side, 0);
            check("t1_qty", out_qty, 100);
            check("t1_price", out_price, 1000);
            check("t1_seq", out_seq, k);
            repeat (19) @(negedge clk);
        end
        check("t1_pos", $signed(position), 300);
        send(SIG_BUY, 1000);
        check("t1_rej_valid", rej_valid, 1);
        check("t1_rej_code", rej_code, 1);
        check("t1_pos_hold", $signed(position), 300);
        check("t1_no_order", out_valid, 0);

        // Burst drains the token bucket; refill allows one more
        do_reset();
        out_ready = 1'b1;
        send(SIG_BUY, 500); send(SIG_SELL, 501); send(SIG_BUY, 502); send(SIG_SELL, 503);
        check("t2_4th_ok", rej_valid, 0);
        send(SIG_BUY, 504);
        check("t2_rej_valid", rej_valid, 1);
        check("t2_rej_code", rej_code, 2);
        repeat (16) @(negedge clk);
        send(SIG_BUY, 600);
        check("t2_refill_ok", rej_valid, 0);
        check("t2_refill_price", out_price, 600);
        check("t2_refill_pos", $signed(position), 100);

        // Queue fills with out_ready low; head holds, then drains in order
        do_reset();
        out_ready = 1'b0;
        send(SIG_BUY, 700); send(SIG_SELL, 701); send(SIG_BUY, 702); send(SIG_SELL, 703);
        check("t3_head_price", out_price, 700);
        repeat (18) @(negedge clk);
        check("t3_hold_valid", out_valid, 1);
        check("t3_hold_price", out_price, 700);
        send(SIG_BUY, 704);
        check("t3_rej_valid", rej_valid, 1);
        check("t3_rej_code", rej_code, 3);
        check("t3_hold_seq", out_seq, 0);
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("t3_drain_price", out_price, 700 + k);
            check("t3_drain_seq", out_seq, k);
        end
        @(negedge clk);
        check("t3_empty", out_valid, 0);

        // FLATTEN bypasses the empty bucket; a second one is dropped silently
        do_reset();
        out_ready = 1'b1;
        send(SIG_BUY, 1000); send(SIG_BUY, 1001); send(SIG_BUY, 1002); send(SIG_SELL, 1003);
        check("t4_pos200", $signed(position), 200);
        send(SIG_FLAT, 1050);
        check("t4_no_rej", rej_valid, 0);
        check("t4_side", out_side, 1);
        check("t4_qty", out_qty, 200);
        check("t4_price", out_price, 1050);
        check("t4_pos0", $signed(position), 0);
        send(SIG_FLAT, 1060);
        check("t4_drop_rej", rej_valid, 0);
        check("t4_drop_order", out_valid, 0);

        // Kill with orders queued: queue drains, BUY rejected, resume restores trading
        do_reset();
        out_ready = 1'b0;
        send(SIG_BUY, 800); send(SIG_SELL, 801);
        kill = 1'b1; @(negedge clk); kill = 1'b0;
        check("t5_halted", halted, 1);
        send(SIG_BUY, 802);
        check("t5_rej_valid", rej_valid, 1);
        check("t5_rej_code", rej_code, 0);
        check("t5_head", out_price, 800);
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_second", out_price, 801);
        @(negedge clk);
        check("t5_drained", out_valid, 0);
        kill = 1'b1; resume = 1'b1; @(negedge clk); kill = 1'b0; resume = 1'b0;
        check("t5_kill_wins", halted, 1);
        resume = 1'b1; @(negedge clk); resume = 1'b0;
        check("t5_resumed", halted, 0);
        send(SIG_BUY, 803);
        check("t5_buy_ok", rej_valid, 0);
        check("t5_buy_price", out_price, 803);
        check("t5_buy_seq", out_seq, 2);

        // Asynchronous reset while an order is held
        out_ready = 1'b0;
        @(negedge clk);
        send(SIG_BUY, 900);
        check("t6_held", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_price", out_price, 0);
        check("t6_rst_seq", out_seq, 0);
        check("t6_rst_pos", $signed(position), 0);
        check("t6_rst_rej", rej_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        send(SIG_BUY, 901);
        check("t6_seq0", out_seq, 0);
        check("t6_price", out_price, 901);
        send(SIG_SELL, 902); send(SIG_BUY, 903); send(SIG_SELL, 904);
        check("t6_full_bucket", rej_valid, 0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
